// File: rtl/io_pkg.sv
// Shared definitions for the I/O cycle sequencer: port addresses, FSM states
// and the decoded-port flag bundle.
package io_pkg;

  localparam logic [7:0] PORT_CON_STAT = 8'h00;
  localparam logic [7:0] PORT_CON_DATA = 8'h01;
  localparam logic [7:0] PORT_FBAR     = 8'h06;
  localparam logic [7:0] PORT_MISC     = 8'h07;
  localparam logic [7:0] PORT_BANK     = 8'h36;
  localparam logic [7:0] PORT_FF       = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    COMPLETE,
    HOLD
  } seqState_t;

  typedef struct packed {
    logic con;
    logic fbar;
    logic misc;
    logic bank;
    logic ff;
  } portHits_t;

endpackage

// File: rtl/io_port_map.sv
// Combinational I/O address decoder: one hit flag per port plus per-direction
// "mapped" flags.
module io_port_map
  import io_pkg::*;
(
  input  logic [7:0] address,
  output portHits_t  hits,
  output logic       rdMapped,
  output logic       wrMapped
);

  // Ports 07h and FFh are write-only, ports 00h/01h are read-only.
  always_comb begin
    hits      = '0;
    hits.con  = (address == PORT_CON_STAT) || (address == PORT_CON_DATA);
    hits.fbar = (address == PORT_FBAR);
    hits.misc = (address == PORT_MISC);
    hits.bank = (address == PORT_BANK);
    hits.ff   = (address == PORT_FF);
    rdMapped  = hits.con | hits.fbar | hits.bank;
    wrMapped  = hits.fbar | hits.misc | hits.bank | hits.ff;
  end

endmodule

// File: rtl/io_cycle_sequencer.sv
// CPU I/O cycle sequencer: stretches each I/O access by a fixed number of wait
// states, then performs the register write or returns read data.
module io_cycle_sequencer
  import io_pkg::*;
#(
  parameter int         WAIT_STATES = 2,
  parameter logic [7:0] LED_INIT    = 8'h00
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] address,
  input  logic       io_wr_req,
  input  logic       io_rd_req,
  input  logic [7:0] wr_data,
  input  logic [7:0] con_status,
  input  logic [7:0] switches,
  output logic       cpu_wait,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [7:0] fbar_leds,
  output logic [7:0] misc_ctl,
  output logic       ram_a16,
  output logic [7:0] port_ff,
  output logic       bus_err
);

  localparam logic [3:0] LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  seqState_t  state;
  logic [7:0] addrReg;
  logic [7:0] dataReg;
  logic       isWrite;
  logic [3:0] waitCnt;
  logic       errLock;

  logic       anyReq;
  logic       bothReq;
  logic       oneReq;
  logic       goComplete;
  logic       accessMapped;
  logic [7:0] readValue;
  portHits_t  hits;
  logic       rdMapped;
  logic       wrMapped;

  io_port_map portMap (
    .address  (addrReg),
    .hits     (hits),
    .rdMapped (rdMapped),
    .wrMapped (wrMapped)
  );

  assign anyReq       = io_rd_req | io_wr_req;
  assign bothReq      = io_rd_req & io_wr_req;
  assign oneReq       = io_rd_req ^ io_wr_req;
  assign accessMapped = isWrite ? wrMapped : rdMapped;
  assign goComplete   = anyReq &&
                        (((state == ACCESS) && (WAIT_STATES == 0)) ||
                         ((state == WAIT) && (waitCnt == LAST_WAIT)));

  // An illegal dual request or a locked-out IDLE never stalls the CPU.
  assign cpu_wait = ((state == ACCESS) || (state == WAIT)) ? anyReq
                  : ((state == IDLE) && oneReq && !errLock);

  always_comb begin
    readValue = 8'hFF;
    if (hits.con)       readValue = con_status;
    else if (hits.fbar) readValue = fbar_leds;
    else if (hits.bank) readValue = switches;
  end

  // errLock blocks both a repeated bus_err and a new access until the bus
  // has been fully idle for a cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      addrReg   <= 8'h00;
      dataReg   <= 8'h00;
      isWrite   <= 1'b0;
      errLock   <= 1'b0;
      fbar_leds <= LED_INIT;
      misc_ctl  <= 8'h00;
      ram_a16   <= 1'b0;
      port_ff   <= 8'h00;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (!anyReq) errLock <= 1'b0;

      case (state)
        IDLE: begin
          if (bothReq && !errLock) begin
            bus_err <= 1'b1;
            errLock <= 1'b1;
          end else if (oneReq && !errLock) begin
            addrReg <= address;
            dataReg <= wr_data;
            isWrite <= io_wr_req;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          waitCnt <= 4'd0;
          if (!anyReq)              state <= IDLE;
          else if (WAIT_STATES > 0) state <= WAIT;
          else                      state <= COMPLETE;
        end
        WAIT: begin
          if (!anyReq) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
          end else if (waitCnt == LAST_WAIT) begin
            state <= COMPLETE;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        COMPLETE: begin
          if (isWrite) begin
            if (hits.fbar) fbar_leds <= dataReg;
            if (hits.misc) misc_ctl  <= dataReg;
            if (hits.bank) ram_a16   <= dataReg[0];
            if (hits.ff)   port_ff   <= dataReg;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (!anyReq) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (goComplete) begin
        bus_err <= !accessMapped;
        if (!isWrite) begin
          rd_data  <= readValue;
          rd_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_cycle_sequencer.sv
// Randomized self-checking bench for io_cycle_sequencer against a
// transaction-level model of the I/O register file and cycle timing.
module tb_io_cycle_sequencer;

  localparam int         WS          = 2;
  localparam logic [7:0] LED_INIT_TB = 8'h81;

  logic       clock;
  logic       reset_n;
  logic [7:0] address;
  logic       io_wr_req;
  logic       io_rd_req;
  logic [7:0] wr_data;
  logic [7:0] con_status;
  logic [7:0] switches;
  logic       cpu_wait;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] fbar_leds;
  logic [7:0] misc_ctl;
  logic       ram_a16;
  logic [7:0] port_ff;
  logic       bus_err;

  int checkCount = 0;
  int passCount  = 0;

  logic [7:0] mLeds;
  logic [7:0] mMisc;
  logic       mBank;
  logic [7:0] mFf;

  io_cycle_sequencer #(
    .WAIT_STATES (WS),
    .LED_INIT    (LED_INIT_TB)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .address    (address),
    .io_wr_req  (io_wr_req),
    .io_rd_req  (io_rd_req),
    .wr_data    (wr_data),
    .con_status (con_status),
    .switches   (switches),
    .cpu_wait   (cpu_wait),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fbar_leds  (fbar_leds),
    .misc_ctl   (misc_ctl),
    .ram_a16    (ram_a16),
    .port_ff    (port_ff),
    .bus_err    (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] modelRead(input logic [7:0] addr);
    case (addr)
      8'h00, 8'h01: return con_status;
      8'h06:        return mLeds;
      8'h36:        return switches;
      default:      return 8'hFF;
    endcase
  endfunction

  function automatic bit modelMapped(input bit isWr, input logic [7:0] addr);
    if (isWr) return (addr == 8'h06) || (addr == 8'h07) || (addr == 8'h36) || (addr == 8'hFF);
    return (addr == 8'h00) || (addr == 8'h01) || (addr == 8'h06) || (addr == 8'h36);
  endfunction

  function automatic void modelReset();
    mLeds = LED_INIT_TB;
    mMisc = 8'h00;
    mBank = 1'b0;
    mFf   = 8'h00;
  endfunction

  task automatic checkRegisters(input string tag);
    checkOutput({tag, "_leds"}, fbar_leds, mLeds);
    checkOutput({tag, "_misc"}, misc_ctl, mMisc);
    checkOutput({tag, "_bank"}, ram_a16, mBank);
    checkOutput({tag, "_ff"}, port_ff, mFf);
  endtask

  // One CPU access with the request held for holdCycles cycles; a hold shorter
  // than the full stall length aborts the access before it completes.
  task automatic applyStimulus(input bit isWr, input logic [7:0] addr, input logic [7:0] data, input int holdCycles);
    int         waitCyc  = 0;
    int         errCnt   = 0;
    int         validCnt = 0;
    int         compIdx  = -1;
    logic [7:0] compData = 8'h00;
    logic [7:0] ledsAtComplete = 8'h00;
    logic [7:0] ledsAfter      = 8'h00;
    logic [7:0] oldLeds  = mLeds;
    bit         full     = (holdCycles > 2 + WS);
    bit         mapped   = modelMapped(isWr, addr);
    logic [7:0] expRead  = modelRead(addr);

    address   = addr;
    wr_data   = data;
    io_wr_req = isWr;
    io_rd_req = !isWr;
    for (int c = 0; c < holdCycles + 2; c++) begin
      @(negedge clock);
      if (cpu_wait) waitCyc++;
      if (bus_err)  errCnt++;
      if (rd_valid) validCnt++;
      if (compIdx < 0 && c > 0 && !cpu_wait && c < holdCycles) begin
        compIdx  = c;
        compData = rd_data;
      end
      if (c == 2 + WS) ledsAtComplete = fbar_leds;
      if (c == 3 + WS) ledsAfter = fbar_leds;
      nextCycle();
      if (c == holdCycles - 1) begin
        io_wr_req = 1'b0;
        io_rd_req = 1'b0;
      end
    end

    if (full) begin
      checkOutput("wait_cycles", waitCyc, 2 + WS);
      checkOutput("complete_cycle", compIdx, 2 + WS);
      checkOutput("bus_err_pulses", errCnt, mapped ? 0 : 1);
      if (isWr) begin
        checkOutput("wr_valid_cycles", validCnt, 0);
        if (addr == 8'h06) begin
          checkOutput("leds_at_complete", ledsAtComplete, oldLeds);
          checkOutput("leds_after_complete", ledsAfter, data);
        end
        case (addr)
          8'h06:   mLeds = data;
          8'h07:   mMisc = data;
          8'h36:   mBank = data[0];
          8'hFF:   mFf   = data;
          default: ;
        endcase
      end else begin
        checkOutput("rd_data", compData, expRead);
        checkOutput("rd_valid_cycles", validCnt, holdCycles - (2 + WS) + 1);
      end
    end else begin
      checkOutput("abort_wait_cycles", waitCyc, holdCycles);
      checkOutput("abort_completed", compIdx, -1);
      checkOutput("abort_bus_err", errCnt, 0);
      checkOutput("abort_rd_valid", validCnt, 0);
    end
    checkRegisters(full ? "access" : "abort");
  endtask

  task automatic applyBothRequests(input int cycles);
    int errCnt   = 0;
    int waitCyc  = 0;
    int validCnt = 0;
    address   = 8'h06;
    wr_data   = 8'h3C;
    io_wr_req = 1'b1;
    io_rd_req = 1'b1;
    for (int c = 0; c < cycles + 2; c++) begin
      @(negedge clock);
      if (bus_err)  errCnt++;
      if (cpu_wait) waitCyc++;
      if (rd_valid) validCnt++;
      nextCycle();
      if (c == cycles - 1) begin
        io_wr_req = 1'b0;
        io_rd_req = 1'b0;
      end
    end
    checkOutput("both_bus_err_pulses", errCnt, 1);
    checkOutput("both_cpu_wait", waitCyc, 0);
    checkOutput("both_rd_valid", validCnt, 0);
    checkRegisters("both");
  endtask

  task automatic applyResetInWait(input logic [7:0] data);
    address   = 8'h07;
    wr_data   = data;
    io_wr_req = 1'b1;
    io_rd_req = 1'b0;
    nextCycle();
    nextCycle();
    reset_n = 1'b0;
    nextCycle();
    reset_n   = 1'b1;
    io_wr_req = 1'b0;
    modelReset();
    for (int c = 0; c < 4 + WS; c++) begin
      @(negedge clock);
      checkOutput("rst_wait_rd_valid", rd_valid, 1'b0);
      checkOutput("rst_wait_cpu_wait", cpu_wait, 1'b0);
      nextCycle();
    end
    checkRegisters("rst_wait");
    checkOutput("rst_wait_rd_data", rd_data, 8'h00);
  endtask

  initial begin
    logic [7:0] addrList [6];
    addrList = '{8'h00, 8'h01, 8'h06, 8'h07, 8'h36, 8'hFF};

    reset_n    = 1'b0;
    address    = 8'h00;
    io_wr_req  = 1'b0;
    io_rd_req  = 1'b0;
    wr_data    = 8'h00;
    con_status = 8'h00;
    switches   = 8'h00;
    modelReset();
    repeat (3) nextCycle();
    @(negedge clock);
    checkRegisters("reset");
    checkOutput("reset_rd_data", rd_data, 8'h00);
    checkOutput("reset_rd_valid", rd_valid, 1'b0);
    checkOutput("reset_bus_err", bus_err, 1'b0);
    checkOutput("reset_cpu_wait", cpu_wait, 1'b0);
    reset_n = 1'b1;
    nextCycle();

    applyStimulus(1'b1, 8'h06, 8'hA5, 3 + WS);
    switches = 8'h3C;
    applyStimulus(1'b0, 8'h36, 8'h00, 5 + WS);
    applyStimulus(1'b1, 8'h36, 8'hFE, 3 + WS);
    applyStimulus(1'b1, 8'h36, 8'h01, 3 + WS);
    con_status = 8'h5E;
    applyStimulus(1'b0, 8'h01, 8'h00, 3 + WS);
    applyStimulus(1'b0, 8'h55, 8'h00, 4 + WS);
    applyStimulus(1'b1, 8'h55, 8'h77, 3 + WS);
    applyStimulus(1'b0, 8'h07, 8'h00, 3 + WS);
    applyBothRequests(5);
    applyStimulus(1'b0, 8'h06, 8'h00, 3 + WS);
    applyStimulus(1'b1, 8'h07, 8'h99, 2);
    applyStimulus(1'b1, 8'h07, 8'h99, 1);
    applyResetInWait(8'hC3);

    for (int i = 0; i < 60; i++) begin
      bit         isWr = 1'($urandom_range(0, 1));
      logic [7:0] addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : addrList[$urandom_range(0, 5)];
      int         hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 1 + WS) : $urandom_range(3 + WS, 6 + WS);
      con_status = 8'($urandom);
      switches   = 8'($urandom);
      if ($urandom_range(0, 9) == 0) applyBothRequests($urandom_range(1, 4));
      else applyStimulus(isWr, addr, 8'($urandom), hold);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
